// File: rtl/adc128s022_responder.sv
// ADC128S022 serial-interface responder: decodes the channel address shifted in on din and
// returns the addressed channel on dout one frame later, oversampling all pins on clk_50.
module adc128s022_responder #(
    parameter int DATA_W      = 12,
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic                   clk_50,
    input  logic                   rst_n,
    input  logic                   adc_cs_n,
    input  logic                   adc_sck,
    input  logic                   din,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    output logic                   dout,
    output logic                   dout_oe,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic [2:0]             cur_addr
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_din_sync;
    logic                   r_cs_prev, r_sck_prev;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_sr, w_sr_nxt;
    logic [2:0]        r_addr_sr, w_addr_sr_nxt;
    logic [2:0]        r_next_addr, w_next_addr_nxt;
    logic [2:0]        r_cur_addr, w_cur_addr_nxt;
    logic              r_dout, w_dout_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_frame_abort, w_frame_abort_nxt;
    logic              r_wrapped, w_wrapped_nxt;

    logic              w_cs, w_sck, w_din;
    logic              w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
    logic [DATA_W-1:0] w_ch_word;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            // NOTE: cs chain resets to "selected" so a cs_n already low after reset never looks like a fresh fall.
            r_cs_sync  <= '0;
            r_sck_sync <= '0;
            r_din_sync <= '0;
            r_cs_prev  <= 1'b0;
            r_sck_prev <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], adc_sck};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
            r_cs_prev  <= w_cs;
            r_sck_prev <= w_sck;
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_din      = r_din_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_prev & ~w_cs;
    assign w_cs_rise  = ~r_cs_prev & w_cs;
    assign w_sck_rise = ~r_sck_prev & w_sck & ~w_cs;
    assign w_sck_fall = r_sck_prev & ~w_sck & ~w_cs;
    assign w_ch_word  = ch_data[int'(r_cur_addr)*DATA_W +: DATA_W];

    // State register together with the datapath registers it sequences.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_sr          <= '0;
            r_addr_sr     <= '0;
            r_next_addr   <= '0;
            r_cur_addr    <= '0;
            r_dout        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_wrapped     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_sr          <= w_sr_nxt;
            r_addr_sr     <= w_addr_sr_nxt;
            r_next_addr   <= w_next_addr_nxt;
            r_cur_addr    <= w_cur_addr_nxt;
            r_dout        <= w_dout_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_frame_abort <= w_frame_abort_nxt;
            r_wrapped     <= w_wrapped_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_cs_fall) w_state_nxt = ACTIVE;
            ACTIVE: if (w_cs_rise) w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_bit_cnt_nxt     = r_bit_cnt;
        w_sr_nxt          = r_sr;
        w_addr_sr_nxt     = r_addr_sr;
        w_next_addr_nxt   = r_next_addr;
        w_cur_addr_nxt    = r_cur_addr;
        w_dout_nxt        = r_dout;
        w_wrapped_nxt     = r_wrapped;
        w_frame_done_nxt  = 1'b0;
        w_frame_abort_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_dout_nxt     = 1'b0;
                w_bit_cnt_nxt  = '0;
                w_cur_addr_nxt = r_next_addr;
                if (w_cs_fall) w_wrapped_nxt = 1'b0;
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_dout_nxt        = 1'b0;
                    w_bit_cnt_nxt     = '0;
                    w_cur_addr_nxt    = r_next_addr;
                    w_frame_abort_nxt = (r_bit_cnt != 4'd0) || !r_wrapped;
                end else if (w_sck_rise) begin
                    w_wrapped_nxt = 1'b0;
                    case (r_bit_cnt)
                        4'd2:  w_addr_sr_nxt[2] = w_din;
                        4'd3:  w_addr_sr_nxt[1] = w_din;
                        4'd4:  w_addr_sr_nxt[0] = w_din;
                        4'd15: begin
                            w_next_addr_nxt  = r_addr_sr;
                            w_frame_done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (w_sck_fall) begin
                    w_wrapped_nxt = 1'b0;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd3) begin
                        w_sr_nxt   = w_ch_word;
                        w_dout_nxt = w_ch_word[DATA_W-1];
                    end else if (r_bit_cnt >= 4'd4 && r_bit_cnt <= 4'd14) begin
                        // Rotate rather than shift; the wrapped bit is never driven out.
                        w_sr_nxt   = {r_sr[DATA_W-2:0], r_sr[DATA_W-1]};
                        w_dout_nxt = r_sr[DATA_W-2];
                    end else if (r_bit_cnt == 4'd15) begin
                        w_cur_addr_nxt = r_next_addr;
                        w_dout_nxt     = 1'b0;
                        w_wrapped_nxt  = 1'b1;
                    end else begin
                        w_dout_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        dout        = r_dout;
        dout_oe     = (r_state == ACTIVE);
        frame_done  = r_frame_done;
        frame_abort = r_frame_abort;
        cur_addr    = r_cur_addr;
    end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Directed bench for adc128s022_responder: drives frames at 2.5 MHz SCK and compares every
// settled cycle against a bit-index model of the returned words, plus literal word checks.
module tb_adc128s022_responder;

    localparam int DATA_W      = 12;
    localparam int N_CH        = 8;
    localparam int SYNC_STAGES = 2;

    logic                   clk_50   = 1'b0;
    logic                   rst_n    = 1'b0;
    logic                   adc_cs_n = 1'b1;
    logic                   adc_sck  = 1'b0;
    logic                   din      = 1'b0;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic                   dout, dout_oe, frame_done, frame_abort;
    logic [2:0]             cur_addr;

    int total     = 0;
    int bad       = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    bit chk_en    = 1'b0;

    // Model state: pending/current channel, SCK cycle index, word in flight.
    bit          m_active;
    int          m_n;
    logic [2:0]  m_pend, m_cur, m_addr;
    logic [15:0] m_word;
    bit          m_wrapped;
    logic        exp_dout, exp_oe, exp_done_now, exp_abort_now;
    logic [2:0]  exp_cur;
    logic [15:0] rx_word;

    adc128s022_responder #(
        .DATA_W(DATA_W), .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_50(clk_50), .rst_n(rst_n), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .din(din),
        .ch_data(ch_data), .dout(dout), .dout_oe(dout_oe), .frame_done(frame_done),
        .frame_abort(frame_abort), .cur_addr(cur_addr)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ch_get(input int k);
        return ch_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic ch_set(input int k, input logic [11:0] v);
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic abit(input logic [2:0] a, input int k);
        case (k)
            2:       return a[2];
            3:       return a[1];
            4:       return a[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_cs_fall();
        if (!m_active) begin
            m_active = 1; m_n = 0; m_cur = m_pend; m_wrapped = 0;
            exp_oe = 1; exp_dout = 0; exp_cur = m_cur;
        end
    endtask

    task automatic m_cs_rise();
        if (m_active) begin
            exp_abort_now = (m_n != 0) || !m_wrapped;
            m_active = 0; exp_oe = 0; exp_dout = 0; exp_cur = m_pend;
        end
    endtask

    task automatic m_sck_rise();
        if (m_active) begin
            m_wrapped = 0;
            if (m_n == 2) m_addr = {2'b00, din};
            else if (m_n == 3 || m_n == 4) m_addr = {m_addr[1:0], din};
            if (m_n == 15) begin
                m_pend = m_addr; exp_done_now = 1;
            end
        end
    endtask

    task automatic m_sck_fall();
        if (m_active) begin
            m_wrapped = 0;
            if (m_n == 3) m_word = {4'h0, ch_get(int'(m_cur))};
            if (m_n == 15) begin
                exp_dout = 0; m_n = 0; m_cur = m_pend; exp_cur = m_cur; m_wrapped = 1;
            end else begin
                exp_dout = (m_n < 3) ? 1'b0 : m_word[14-m_n];
                m_n++;
            end
        end
    endtask

    // Outputs settle SYNC_STAGES+1 clocks after a pin edge; check from then until the next edge.
    task automatic settle();
        repeat (SYNC_STAGES + 1) @(posedge clk_50);
        #1 chk_en = 1;
        @(posedge clk_50);
        #1 exp_done_now = 0; exp_abort_now = 0;
        repeat (6) @(posedge clk_50);
        #1 chk_en = 0;
    endtask

    task automatic cs_low();  adc_cs_n = 0; m_cs_fall(); settle(); endtask
    task automatic cs_high(); adc_cs_n = 1; m_cs_rise(); settle(); endtask

    task automatic sck_rise();
        rx_word = {rx_word[14:0], dout};
        adc_sck = 1; m_sck_rise(); settle();
    endtask

    task automatic sck_fall(input logic d);
        adc_sck = 0; din = d; m_sck_fall(); settle();
    endtask

    task automatic sck_cycles(input logic [2:0] a, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            sck_rise();
            sck_fall(abit(a, n + 1));
        end
    endtask

    task automatic pulse_reset();
        chk_en = 0; rst_n = 0;
        m_active = 0; m_n = 0; m_pend = 0; m_cur = 0; m_addr = 0; m_wrapped = 0; m_word = 0;
        exp_dout = 0; exp_oe = 0; exp_cur = 0; exp_done_now = 0; exp_abort_now = 0;
        @(posedge clk_50);
        #1 rst_n = 1;
        settle();
    endtask

    task automatic frame(input logic [2:0] a, input logic [15:0] word, input string name);
        cs_low();
        sck_cycles(a, 0, 15);
        check(name, rx_word, word);
        cs_high();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_50);
                if (frame_done === 1'b1)  done_cnt++;
                if (frame_abort === 1'b1) abort_cnt++;
                if (chk_en) begin
                    check("dout", dout, exp_dout);
                    check("dout_oe", dout_oe, exp_oe);
                    check("cur_addr", cur_addr, exp_cur);
                    check("frame_done", frame_done, exp_done_now);
                    check("frame_abort", frame_abort, exp_abort_now);
                end
            end
        join_none

        ch_data = '0;
        ch_set(0, 12'h123); ch_set(1, 12'h3C4); ch_set(2, 12'h0F0); ch_set(3, 12'h800);
        ch_set(4, 12'h001); ch_set(5, 12'hABC); ch_set(6, 12'h5A5); ch_set(7, 12'hFFF);
        rx_word = 0;

        pulse_reset();
        check("rst_dout", dout, 0);
        check("rst_oe", dout_oe, 0);
        check("rst_cur_addr", cur_addr, 0);
        check("rst_done", frame_done, 0);
        check("rst_abort", frame_abort, 0);

        cs_low();
        check("f1_cur_addr", cur_addr, 3'd0);
        sck_cycles(3'd5, 0, 15);
        check("f1_word", rx_word, 16'h0123);
        cs_high();
        check("f1_done_cnt", done_cnt, 1);
        frame(3'd6, 16'h0ABC, "f2_word");
        frame(3'd3, 16'h05A5, "f3_word");
        check("f3_done_cnt", done_cnt, 3);

        // Back-to-back frames with cs_n held low.
        cs_low();
        sck_cycles(3'd7, 0, 15); check("b2b1_word", rx_word, 16'h0800);
        check("b2b1_oe", dout_oe, 1);
        sck_cycles(3'd7, 0, 15); check("b2b2_word", rx_word, 16'h0FFF);
        sck_cycles(3'd0, 0, 15); check("b2b3_word", rx_word, 16'h0FFF);
        cs_high();
        check("b2b_done_cnt", done_cnt, 6);
        check("b2b_abort_cnt", abort_cnt, 0);

        // Abort after 9 SCK cycles; pending channel (0) must survive.
        cs_low();
        sck_cycles(3'd5, 0, 8);
        cs_high();
        check("abort_cnt", abort_cnt, 1);
        check("abort_oe", dout_oe, 0);
        check("abort_done_cnt", done_cnt, 6);
        frame(3'd5, 16'h0123, "post_abort_word");

        // ch5 changes mid-word: word in flight is unaffected.
        cs_low();
        check("chg_cur_addr", cur_addr, 3'd5);
        sck_cycles(3'd5, 0, 7);
        ch_set(5, 12'h111);
        sck_cycles(3'd5, 8, 15);
        check("chg_word", rx_word, 16'h0ABC);
        cs_high();
        frame(3'd2, 16'h0111, "chg_next_word");
        check("chg_done_cnt", done_cnt, 9);

        // Reset mid-frame with cs_n held low.
        cs_low();
        sck_cycles(3'd4, 0, 5);
        pulse_reset();
        sck_cycles(3'd4, 6, 15);
        check("rstmid_oe", dout_oe, 0);
        check("rstmid_done_cnt", done_cnt, 9);
        cs_high();
        frame(3'd1, 16'h0123, "rstmid_next_word");
        check("final_done_cnt", done_cnt, 10);
        check("final_abort_cnt", abort_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc128s022_responder.md
Name: adc128s022_responder

Overview:
- Synthesizable responder for the ADC128S022 serial interface.
- Sits on the adc_cs_n / adc_sck / din / dout pins in place of the physical converter, for FPGA loopback and closed-loop bring-up of the ADC controller.
- Decodes the 3-bit channel address shifted in on din.
- Returns the 12-bit value of the addressed channel on dout in the following frame, with the same pipelined timing as the device.
- All logic runs on the 50 MHz system clock; the serial lines are oversampled.

Parameters:
- DATA_W, 12, sample width per channel.
- N_CH, 8, number of channels (address width fixed at 3).
- SYNC_STAGES, 2, synchronizer depth on adc_cs_n, adc_sck, din.

Ports:
- clk_50  in  1  50 MHz system clock.
- rst_n  in  1  synchronous active-low reset.
- adc_cs_n  in  1  chip select from controller, active low.
- adc_sck  in  1  serial clock from controller, ≤2.5 MHz.
- din  in  1  serial address from controller.
- ch_data  in  N_CH*DATA_W  channel values, flattened; ch k occupies bits [k*12+11:k*12].
- dout  out  1  serial data to controller.
- dout_oe  out  1  high while selected (pad tri-state control).
- frame_done  out  1  one-cycle pulse on 16th rising SCK edge of a frame.
- frame_abort  out  1  one-cycle pulse when cs_n rises mid-frame.
- cur_addr  out  3  address used for the conversion currently being shifted out.

Behaviour:
- Single clock, clk_50. Reset is synchronous and active-low on rst_n.
- Reset values: dout=0, dout_oe=0, frame_done=0, frame_abort=0, cur_addr=0, next_addr=0, bit_cnt=0, shift reg=0.
- Synchronization and edge detection:
  - adc_cs_n, adc_sck and din each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies: sck_rise, sck_fall, cs_fall, cs_rise.
  - Every output reacts SYNC_STAGES+1 clk_50 cycles after the pin edge.
- States:
  - IDLE (cs_n high).
  - ACTIVE (cs_n low).
- IDLE:
  - dout=0, dout_oe=0, bit_cnt=0.
  - On cs_fall: go to ACTIVE, dout_oe=1, dout=0 (DB15 leading zero).
  - cur_addr is set to next_addr.
- ACTIVE, bit_cnt n = 0..15 (SCK cycle index):
  - On sck_rise with n=2,3,4: capture synced din into addr_sr bit ADD2, ADD1, ADD0 respectively. Other rising edges ignore din.
  - On sck_rise with n=15: next_addr<=addr_sr, pulse frame_done.
  - On sck_fall with n=0,1,2: dout=0 (leading zeros DB14..DB12); increment n.
  - On sck_fall with n=3: load the shift reg with ch_data[cur_addr], dout=DB11 (MSB); increment n.
  - On sck_fall with n=4..14: shift left, dout=next bit (DB10..DB0); increment n.
  - On sck_fall with n=15: wrap n to 0, cur_addr<=next_addr, dout=0. This is back-to-back frame support while cs_n stays low.
- Frame end and abort:
  - cs_rise: go to IDLE, dout=0, dout_oe=0.
  - If bit_cnt≠0, or the last edge was not the 16th fall, pulse frame_abort. next_addr is not updated unless the n=15 rise already occurred.
- next_addr persists across cs_n high periods. The first frame after reset converts channel 0.
- ch_data is sampled only at the n=3 fall. Changes at other times do not affect the word in flight.
- Simultaneous events:
  - sck edges are ignored while synced cs_n is high.
  - cs_fall and sck_fall in the same clk_50 cycle: cs_fall takes priority; the sck edge is dropped.
- rst_n low mid-frame: all state returns to reset values next clock. The responder stays in IDLE until a fresh cs_fall, even if cs_n is already low.
- Arithmetic: bit_cnt is 4-bit and wraps modulo 16. No other arithmetic.

Test Plan:
- Reset, then one frame with din address 101 and ch_data ch0=0x123, ch5=0xABC.
  - dout = 0000_0001_0010_0011 (ch0, since no address is pending).
  - cur_addr=0; frame_done pulses once; next_addr becomes 5.
- Second frame after the first, with din address 110 and ch6=0x5A5.
  - dout returns 0xABC behind 4 leading zeros.
  - After the frame, next_addr=6.
  - A third frame returns 0x5A5.
- cs_n held low across 3 consecutive 16-SCK frames with addresses 7, 7, 0 and ch7=0xFFF.
  - Words returned: previous address value, 0xFFF, 0xFFF.
  - dout_oe stays 1; frame_done pulses 3 times.
- cs_n raised after 9 SCK cycles.
  - frame_abort pulses; dout_oe=0 within SYNC_STAGES+1 cycles.
  - next_addr is unchanged; the following full frame returns the previously pending channel.
- ch_data[ch5] changed from 0xABC to 0x111 at SCK cycle 8 of a ch5 frame.
  - 0xABC is shifted out in full; the next ch5 frame returns 0x111.
- rst_n asserted for 1 cycle at SCK cycle 6 with cs_n held low.
  - dout=0, dout_oe=0 and stay so; no frame_done.
  - After cs_n high then low, a frame returns the ch0 value.
